// File: rtl/cpu_ctrl_seq.sv
// 6502-style control sequencer: reset vectoring, fetch/decode, JMP abs/ind, BRK and NMI/IRQ entry.
// Optional memory-stall handshake enabled by defining CTRL_STALL_EN.
module cpu_ctrl_seq #(
  parameter int unsigned       ADDR_W  = 16,
  parameter int unsigned       CYC_W   = 4,
  parameter logic [ADDR_W-1:0] VEC_NMI = 16'hFFFA,
  parameter logic [ADDR_W-1:0] VEC_RST = 16'hFFFC,
  parameter logic [ADDR_W-1:0] VEC_IRQ = 16'hFFFE
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              NMI,
  input  logic              IRQ,
  input  logic              I_flag,
  input  logic [7:0]        opcode,
  input  logic [CYC_W-1:0]  op_cycles,
  input  logic              mem_ready,
  output logic [1:0]        pc_op,
  output logic              pc_src,
  output logic [1:0]        mem_op,
  output logic [1:0]        addr_sel,
  output logic [1:0]        wdata_sel,
  output logic              sp_dec,
  output logic              set_I,
  output logic [ADDR_W-1:0] vector,
  output logic              sync
);

  typedef enum logic [3:0] {
    StRst0, StRst1, StRst2, StFetch, StDecode, StJmp0, StInd0, StBrk0, StWait,
    StInt0, StInt1, StInt2, StInt3, StInt4, StInt5
  } state_e;

  state_e             state_q, state_d;
  logic [CYC_W-1:0]   cnt_q, cnt_d, cnt_dec, cyc_rem;
  logic               nmi_q, nmi_pend_q, nmi_pend_d, nmi_edge, nmi_hit;
  logic               brk_q, brk_d;
  logic [ADDR_W-1:0]  vector_q, vector_d;
  logic [1:0]         pc_op_q, mem_op_q, addr_sel_q, wdata_sel_q;
  logic               pc_src_q, sp_dec_q, set_i_q, sync_q;
  logic               int_req, stall;
  state_e             exit_st;

`ifdef CTRL_STALL_EN
  assign stall = (mem_op_q != 2'b00) && !mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign stall = 1'b0;
`endif

  assign cnt_dec  = (cnt_q == '0) ? '0 : cnt_q - CYC_W'(1);
  assign cyc_rem  = (op_cycles < CYC_W'(2)) ? '0 : op_cycles - CYC_W'(2);
  assign nmi_edge = NMI & ~nmi_q;
  assign nmi_hit  = nmi_pend_q | nmi_edge;
  assign int_req  = nmi_pend_q | (IRQ & ~I_flag);
  assign exit_st  = int_req ? StInt0 : StFetch;

  // cnt_q counts the cycles left in the instruction, including the current one
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_dec;
    brk_d   = brk_q;
    unique case (state_q)
      StRst0:   state_d = StRst1;
      StRst1:   state_d = StRst2;
      StRst2:   state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: begin
        cnt_d = cyc_rem;
        unique case (opcode)
          8'h4C:   state_d = StJmp0;
          8'h6C:   state_d = StInd0;
          8'h00: begin
            state_d = StBrk0;
            brk_d   = 1'b1;
          end
          default: state_d = (cyc_rem == '0) ? exit_st : StWait;
        endcase
      end
      StJmp0:   state_d = (cnt_dec == '0) ? exit_st : StWait;
      StInd0:   state_d = StJmp0;
      StBrk0:   state_d = StInt1;
      StWait:   state_d = (cnt_dec == '0) ? exit_st : StWait;
      StInt0:   state_d = StInt1;
      StInt1:   state_d = StInt2;
      StInt2:   state_d = StInt3;
      StInt3:   state_d = StInt4;
      StInt4:   state_d = StInt5;
      StInt5: begin
        state_d = StFetch;
        brk_d   = 1'b0;
      end
      default:  state_d = StRst0;
    endcase
  end

  // A pending or same-cycle NMI edge seen in INT_3 redirects the entry to the NMI vector
  always_comb begin
    nmi_pend_d = nmi_pend_q | nmi_edge;
    vector_d   = vector_q;
    if (state_q == StInt3) begin
      vector_d = nmi_hit ? VEC_NMI : VEC_IRQ;
      if (nmi_hit) begin
        nmi_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StRst0;
      cnt_q       <= '0;
      nmi_q       <= 1'b0;
      nmi_pend_q  <= 1'b0;
      brk_q       <= 1'b0;
      vector_q    <= VEC_RST;
      pc_op_q     <= 2'b00;
      pc_src_q    <= 1'b0;
      mem_op_q    <= 2'b00;
      addr_sel_q  <= 2'b00;
      wdata_sel_q <= 2'b00;
      sp_dec_q    <= 1'b0;
      set_i_q     <= 1'b0;
      sync_q      <= 1'b0;
    end else if (!stall) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nmi_q       <= NMI;
      nmi_pend_q  <= nmi_pend_d;
      brk_q       <= brk_d;
      vector_q    <= vector_d;
      pc_op_q     <= 2'b00;
      pc_src_q    <= 1'b0;
      mem_op_q    <= 2'b00;
      addr_sel_q  <= 2'b00;
      wdata_sel_q <= 2'b00;
      sp_dec_q    <= 1'b0;
      set_i_q     <= 1'b0;
      sync_q      <= 1'b0;
      unique case (state_d)
        StRst1, StInt4: begin
          addr_sel_q <= 2'b10;
          mem_op_q   <= 2'b10;
        end
        StRst2, StInt5: begin
          pc_op_q  <= 2'b10;
          pc_src_q <= 1'b1;
          set_i_q  <= 1'b1;
        end
        StFetch: begin
          mem_op_q <= 2'b01;
          pc_op_q  <= 2'b01;
          sync_q   <= 1'b1;
        end
        StDecode: mem_op_q <= 2'b10;
        StJmp0:   pc_op_q  <= 2'b10;
        StInd0: begin
          addr_sel_q <= 2'b01;
          mem_op_q   <= 2'b10;
        end
        StBrk0:   pc_op_q <= 2'b01;
        StInt1, StInt2, StInt3: begin
          addr_sel_q  <= 2'b11;
          mem_op_q    <= 2'b11;
          sp_dec_q    <= 1'b1;
          wdata_sel_q <= (state_d == StInt1) ? 2'b00 :
                         (state_d == StInt2) ? 2'b01 : {1'b1, brk_q};
        end
        default: ;
      endcase
    end
  end

  // Side-effect strobes are suppressed while a memory access is stalled
  assign pc_op     = stall ? 2'b00 : pc_op_q;
  assign sp_dec    = sp_dec_q & ~stall;
  assign set_I     = set_i_q & ~stall;
  assign pc_src    = pc_src_q;
  assign mem_op    = mem_op_q;
  assign addr_sel  = addr_sel_q;
  assign wdata_sel = wdata_sel_q;
  assign vector    = vector_q;
  assign sync      = sync_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Self-checking bench for cpu_ctrl_seq: per-instruction expected-cycle queue model plus
// directed vectors with literal expectations.
module tb_cpu_ctrl_seq;

  localparam logic [15:0] VNMI = 16'hFFFA;
  localparam logic [15:0] VRST = 16'hFFFC;
  localparam logic [15:0] VIRQ = 16'hFFFE;

  localparam int T_RST0 = 0, T_RST1 = 1, T_RST2 = 2, T_FETCH = 3, T_DECODE = 4, T_JMP0 = 5;
  localparam int T_IND0 = 6, T_BRK0 = 7, T_WAIT = 8, T_INT0 = 9, T_INT1 = 10, T_INT2 = 11;
  localparam int T_INT3 = 12, T_INT3B = 13, T_INT4 = 14, T_INT5 = 15, T_NONE = -1;

  typedef struct packed {
    logic [1:0] pc_op;
    logic       pc_src;
    logic [1:0] mem_op;
    logic [1:0] addr_sel;
    logic [1:0] wdata_sel;
    logic       sp_dec;
    logic       set_i;
    logic       sync;
  } item_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        NMI = 1'b0;
  logic        IRQ = 1'b0;
  logic        I_flag = 1'b1;
  logic [7:0]  opcode = 8'hEA;
  logic [3:0]  op_cycles = 4'd2;
  logic        mem_ready = 1'b1;
  logic [1:0]  pc_op, mem_op, addr_sel, wdata_sel;
  logic        pc_src, sp_dec, set_I, sync;
  logic [15:0] vector;

  int checks = 0;
  int errors = 0;

  cpu_ctrl_seq dut (
    .CLK(CLK), .RESET(RESET), .NMI(NMI), .IRQ(IRQ), .I_flag(I_flag),
    .opcode(opcode), .op_cycles(op_cycles), .mem_ready(mem_ready),
    .pc_op(pc_op), .pc_src(pc_src), .mem_op(mem_op), .addr_sel(addr_sel),
    .wdata_sel(wdata_sel), .sp_dec(sp_dec), .set_I(set_I), .vector(vector), .sync(sync)
  );

  always #5 CLK = ~CLK;

  // Strobes each cycle type must present, straight from the behaviour tables
  function automatic item_t item_of(input int t);
    item_t it;
    it = '0;
    case (t)
      T_RST1, T_INT4: begin it.addr_sel = 2'b10; it.mem_op = 2'b10; end
      T_RST2, T_INT5: begin it.pc_op = 2'b10; it.pc_src = 1'b1; it.set_i = 1'b1; end
      T_FETCH:  begin it.mem_op = 2'b01; it.pc_op = 2'b01; it.sync = 1'b1; end
      T_DECODE: it.mem_op = 2'b10;
      T_JMP0:   it.pc_op = 2'b10;
      T_IND0:   begin it.addr_sel = 2'b01; it.mem_op = 2'b10; end
      T_BRK0:   it.pc_op = 2'b01;
      T_INT1, T_INT2, T_INT3, T_INT3B: begin
        it.addr_sel = 2'b11; it.mem_op = 2'b11; it.sp_dec = 1'b1;
        it.wdata_sel = (t == T_INT1) ? 2'b00 : (t == T_INT2) ? 2'b01 :
                       (t == T_INT3) ? 2'b10 : 2'b11;
      end
      default: ;
    endcase
    return it;
  endfunction

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Model: queue of upcoming cycle types, refilled at DECODE and at instruction boundaries
  int          q[$];
  int          m_cur = T_RST0;
  bit          m_valid = 1'b0;
  bit          m_pend = 1'b0;
  bit          m_nmi_prev = 1'b0;
  logic [15:0] m_vec = VRST;

  always @(posedge CLK) begin
    bit nedge, stall_now;
    int rem;
    nedge = NMI && !m_nmi_prev;
    stall_now = 1'b0;
`ifdef CTRL_STALL_EN
    stall_now = (item_of(m_cur).mem_op != 2'b00) && !mem_ready;
`endif
    if (RESET) begin
      q = '{T_RST1, T_RST2, T_FETCH, T_DECODE};
      m_cur = T_RST0; m_pend = 1'b0; m_vec = VRST; m_nmi_prev = 1'b0; m_valid = 1'b1;
    end else if (!stall_now) begin
      if (m_cur == T_DECODE) begin
        rem = (op_cycles < 2) ? 0 : int'(op_cycles) - 2;
        case (opcode)
          8'h4C: begin
            q.push_back(T_JMP0);
            for (int i = 0; i < rem - 1; i++) q.push_back(T_WAIT);
          end
          8'h6C: begin
            q.push_back(T_IND0); q.push_back(T_JMP0);
            for (int i = 0; i < rem - 2; i++) q.push_back(T_WAIT);
          end
          8'h00: q = '{T_BRK0, T_INT1, T_INT2, T_INT3B, T_INT4, T_INT5, T_FETCH, T_DECODE};
          default: for (int i = 0; i < rem; i++) q.push_back(T_WAIT);
        endcase
      end
      if (q.size() == 0) begin
        if (m_pend || (IRQ && !I_flag))
          q = '{T_INT0, T_INT1, T_INT2, T_INT3, T_INT4, T_INT5, T_FETCH, T_DECODE};
        else
          q = '{T_FETCH, T_DECODE};
      end
      if (m_cur == T_INT3 || m_cur == T_INT3B) begin
        m_vec = (m_pend || nedge) ? VNMI : VIRQ;
        m_pend = 1'b0;
      end else if (nedge) begin
        m_pend = 1'b1;
      end
      m_nmi_prev = NMI;
      m_cur = q.pop_front();
    end
  end

  always @(negedge CLK) begin
    item_t exp_it, got_it;
    #1;
    if (m_valid) begin
      exp_it = item_of(m_cur);
`ifdef CTRL_STALL_EN
      if (exp_it.mem_op != 2'b00 && !mem_ready) begin
        exp_it.pc_op = 2'b00; exp_it.sp_dec = 1'b0; exp_it.set_i = 1'b0;
      end
`endif
      got_it = {pc_op, pc_src, mem_op, addr_sel, wdata_sel, sp_dec, set_I, sync};
      check($sformatf("strobes_t%0d", m_cur), int'(got_it), int'(exp_it));
      check("vector", int'(vector), int'(m_vec));
    end
  end

  task automatic wait_tag(input int t);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge CLK);
      found = (m_cur == t);
    end
    check($sformatf("reach_t%0d", t), int'(found), 1);
  endtask

  task automatic count_to_sync(input string nm, input int exp_gap);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!sync && n < 40);
    check(nm, n, exp_gap);
  endtask

  // Entered at a negedge in FETCH; runs one instruction up to the next FETCH
  task automatic do_instr(input string nm, input logic [7:0] op, input logic [3:0] cyc,
                          input int exp_gap, input int exp_sp, input logic [5:0] exp_w,
                          input int nmi_tag, input int irq_off_tag);
    int n, nsp;
    logic [5:0] w;
    n = 0; nsp = 0; w = '0;
    opcode = op; op_cycles = cyc;
    do begin
      @(negedge CLK);
      n++;
      if (sp_dec) nsp++;
      if (mem_op == 2'b11) w = {w[3:0], wdata_sel};
      if (m_cur == nmi_tag) NMI = 1'b1;
      if (m_cur == irq_off_tag) IRQ = 1'b0;
    end while (!sync && n < 40);
    NMI = 1'b0;
    check({nm, "_gap"}, n, exp_gap);
    check({nm, "_spdec"}, nsp, exp_sp);
    check({nm, "_wdata"}, int'(w), int'(exp_w));
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_vector", int'(vector), int'(VRST));
    check("rst_sync", int'(sync), 0);
    check("rst_strobes", int'({pc_op, mem_op, addr_sel, sp_dec, set_I}), 0);
    RESET = 1'b0;
    count_to_sync("rst_to_fetch", 3);

    do_instr("jmp_abs", 8'h4C, 4'd3, 3, 0, 6'b0, T_NONE, T_NONE);
    do_instr("jmp_ind", 8'h6C, 4'd5, 5, 0, 6'b0, T_NONE, T_NONE);

    IRQ = 1'b1; I_flag = 1'b0;
    do_instr("irq_nop", 8'hEA, 4'd2, 8, 3, 6'b000110, T_NONE, T_INT0);
    check("irq_vector", int'(vector), int'(VIRQ));

    do_instr("brk_nmi", 8'h00, 4'd7, 8, 3, 6'b000111, T_INT2, T_NONE);
    check("brk_nmi_vector", int'(vector), int'(VNMI));
    check("model_brk_vector", int'(m_vec), int'(VNMI));
    check("brk_nmi_pend", int'(dut.nmi_pend_q), 0);

    IRQ = 1'b1;
    do_instr("irq_drop", 8'hEA, 4'd4, 4, 0, 6'b0, T_NONE, T_WAIT);

    I_flag = 1'b1;
    do_instr("nmi_wait", 8'hEA, 4'd4, 10, 3, 6'b000110, T_WAIT, T_NONE);
    check("nmi_wait_vector", int'(vector), int'(VNMI));

    do_instr("brk_late", 8'h00, 4'd7, 8, 3, 6'b000111, T_INT4, T_NONE);
    check("brk_late_vector", int'(vector), int'(VIRQ));
    do_instr("nmi_defer", 8'hEA, 4'd2, 8, 3, 6'b000110, T_NONE, T_NONE);
    check("nmi_defer_vector", int'(vector), int'(VNMI));

    // Reset mid-entry with an NMI pending
    IRQ = 1'b1; I_flag = 1'b0; opcode = 8'hEA; op_cycles = 4'd2;
    wait_tag(T_INT0);
    NMI = 1'b1;
    wait_tag(T_INT2);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0; NMI = 1'b0; IRQ = 1'b0; I_flag = 1'b1;
    check("rst_mid_pend", int'(dut.nmi_pend_q), 0);
    check("rst_mid_cnt", int'(dut.cnt_q), 0);
    check("rst_mid_vector", int'(vector), int'(VRST));
    count_to_sync("rst_mid_to_fetch", 3);

`ifdef CTRL_STALL_EN
    begin
      int nsync, ninc;
      nsync = 0; ninc = 0;
      opcode = 8'hEA; op_cycles = 4'd2;
      for (int k = 0; k < 4; k++) begin
        if (k > 0) @(negedge CLK);
        mem_ready = (k == 3);
        #1;
        if (sync) nsync++;
        if (pc_op == 2'b01) ninc++;
      end
      check("stall_fetch_cycles", nsync, 4);
      check("stall_pc_inc", ninc, 1);
      count_to_sync("stall_to_fetch", 2);
    end
`endif

    do_instr("jmp_final", 8'h4C, 4'd3, 3, 0, 6'b0, T_NONE, T_NONE);
    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
